reg_bank: RTL and testbench

Parametrised register bank with multi-bit write enables and two registered random-access read ports with write-first bypass. It exposes the lower and upper halves of the bank as packed operand words through a valid/ready snapshot handshake, and tracks per-entry dirty bits between snapshots. It sits between the data-entry path and the adder datapath and replaces the fixed 8×4 register file.

---
 rtl/reg_bank.sv | 97 +++++++++
 tb/tb_reg_bank.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank with shared-data multi-enable writes, two write-first registered
// read ports, and a valid/ready snapshot of the bank halves as packed operand words.
module reg_bank #(
  parameter int WIDTH_IN = 4,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  localparam int OP_W    = WIDTH_IN * DEPTH / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH_IN-1:0] data,
  input  logic [DEPTH-1:0]    en,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [WIDTH_IN-1:0] rdata_a,
  output logic [WIDTH_IN-1:0] rdata_b,
  input  logic                snap_req,
  input  logic                snap_ready,
  output logic                snap_valid,
  output logic [OP_W-1:0]     addA,
  output logic [OP_W-1:0]     addB,
  output logic [DEPTH-1:0]    dirty,
  output logic                snap_drop
);

  localparam int HALF = DEPTH / 2;

  logic [WIDTH_IN-1:0] mem [DEPTH];
  logic [WIDTH_IN-1:0] nxt [DEPTH];
  logic [OP_W-1:0]     pack_a;
  logic [OP_W-1:0]     pack_b;
  logic                accept;
  logic                refuse;

  // Next-state of every entry; clr wins over any enable.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = mem[i];
      if (clr)
        nxt[i] = '0;
      else if (en[i])
        nxt[i] = data;
    end
  end

  always_comb begin
    pack_a = '0;
    pack_b = '0;
    for (int i = 0; i < HALF; i++) begin
      pack_a[i*WIDTH_IN +: WIDTH_IN] = nxt[i];
      pack_b[i*WIDTH_IN +: WIDTH_IN] = nxt[i+HALF];
    end
  end

  // Snapshot handshake: snap_valid marks addA/addB as holding an unconsumed
  // capture; the consumer takes it on any edge where snap_valid & snap_ready.
  // A new request is accepted when the output slot is empty or being consumed
  // in the same cycle; otherwise it is refused and flagged with snap_drop.
  assign accept = snap_req & (~snap_valid | snap_ready);
  assign refuse = snap_req & snap_valid & ~snap_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      addA       <= '0;
      addB       <= '0;
      snap_valid <= 1'b0;
      dirty      <= '0;
      snap_drop  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= nxt[i];
      rdata_a   <= nxt[rd_addr_a];
      rdata_b   <= nxt[rd_addr_b];
      snap_drop <= refuse;
      if (accept) begin
        addA       <= pack_a;
        addB       <= pack_b;
        snap_valid <= 1'b1;
      end else if (snap_valid & snap_ready) begin
        snap_valid <= 1'b0;
      end
      // A same-cycle write is part of the capture, so accept clears everything.
      if (accept)
        dirty <= '0;
      else if (clr)
        dirty <= '1;
      else
        dirty <= dirty | en;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// compared against a behavioural model of the bank and snapshot rules.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  data;
  logic [7:0]  en;
  logic        clr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [3:0]  rdata_a;
  logic [3:0]  rdata_b;
  logic        snap_req;
  logic        snap_ready;
  logic        snap_valid;
  logic [15:0] addA;
  logic [15:0] addB;
  logic [7:0]  dirty;
  logic        snap_drop;

  int num_checks = 0;
  int num_fail   = 0;

  // Reference model state
  logic [3:0]  m_mem [8];
  logic [3:0]  m_ra, m_rb;
  logic [15:0] m_add_a, m_add_b;
  logic        m_valid, m_drop;
  logic [7:0]  m_dirty;

  reg_bank #(.WIDTH_IN(4), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
    .addA(addA), .addB(addB), .dirty(dirty), .snap_drop(snap_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    m_ra = 0; m_rb = 0; m_add_a = 0; m_add_b = 0;
    m_valid = 0; m_drop = 0; m_dirty = 0;
  endtask

  // Apply one clock edge of the bank rules to the model using current inputs.
  task automatic model_edge();
    logic [3:0] nx [8];
    bit take;
    for (int i = 0; i < 8; i++)
      nx[i] = clr ? 4'h0 : (en[i] ? data : m_mem[i]);
    take   = snap_req && (!m_valid || snap_ready);
    m_drop = snap_req && m_valid && !snap_ready;
    m_ra = nx[rd_addr_a];
    m_rb = nx[rd_addr_b];
    if (take) begin
      for (int i = 0; i < 4; i++) begin
        m_add_a[i*4 +: 4] = nx[i];
        m_add_b[i*4 +: 4] = nx[i+4];
      end
      m_valid = 1;
      m_dirty = 0;
    end else begin
      if (m_valid && snap_ready) m_valid = 0;
      m_dirty = clr ? 8'hFF : (m_dirty | en);
    end
    for (int i = 0; i < 8; i++) m_mem[i] = nx[i];
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data = 0; en = 0; clr = 0; rd_addr_a = 0; rd_addr_b = 0;
    snap_req = 0; snap_ready = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      en = 8'($urandom); data = 4'($urandom); snap_req = 1'($urandom);
      tick();
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    num_checks++;
    if ({rdata_a, rdata_b, addA, addB, snap_valid, dirty, snap_drop} !== 50'd0) begin
      num_fail++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rdata_a, rdata_b, addA, addB, snap_valid, dirty, snap_drop});
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    rd_addr_a = 5;
    tick();
    num_checks++;
    if (rdata_a !== 4'h0) begin
      num_fail++;
      $display("FAIL reset_read5 got=%h exp=0", rdata_a);
    end
  endtask

  task automatic test_multi_write();
    idle_inputs();
    en = 8'b1000_0001; data = 4'hA; rd_addr_a = 7;
    tick();
    num_checks++;
    if (rdata_a !== 4'hA) begin
      num_fail++; $display("FAIL bypass_a got=%h exp=a", rdata_a);
    end
    num_checks++;
    if (dirty !== 8'h81) begin
      num_fail++; $display("FAIL dirty_81 got=%h exp=81", dirty);
    end
    en = 0; rd_addr_b = 0;
    tick();
    num_checks++;
    if (rdata_b !== 4'hA) begin
      num_fail++; $display("FAIL read_b0 got=%h exp=a", rdata_b);
    end
  endtask

  task automatic test_snapshot_pack();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      en = 8'(1 << i); data = 4'(i + 1);
      tick();
    end
    en = 0; snap_req = 1;
    tick();
    snap_req = 0;
    num_checks++;
    if ({addA, addB} !== {16'h4321, 16'h8765}) begin
      num_fail++; $display("FAIL pack got=%h_%h exp=4321_8765", addA, addB);
    end
    num_checks++;
    if (snap_valid !== 1'b1 || dirty !== 8'h00) begin
      num_fail++; $display("FAIL pack_flags got valid=%b dirty=%h exp valid=1 dirty=00",
                           snap_valid, dirty);
    end
  endtask

  task automatic test_hold_drop();
    idle_inputs();
    en = 8'h01; data = 4'hF;
    tick();
    en = 0; snap_req = 1;
    tick();
    snap_req = 0;
    num_checks++;
    if (snap_drop !== 1'b1) begin
      num_fail++; $display("FAIL drop_pulse got=%b exp=1", snap_drop);
    end
    num_checks++;
    if (addA !== 16'h4321 || snap_valid !== 1'b1 || dirty[0] !== 1'b1) begin
      num_fail++; $display("FAIL hold got addA=%h valid=%b dirty=%h exp 4321/1/dirty[0]=1",
                           addA, snap_valid, dirty);
    end
    tick();
    num_checks++;
    if (snap_drop !== 1'b0 || addA !== 16'h4321) begin
      num_fail++; $display("FAIL drop_once got drop=%b addA=%h exp 0/4321", snap_drop, addA);
    end
  endtask

  task automatic test_accept_recapture();
    idle_inputs();
    snap_ready = 1; snap_req = 1; en = 8'h02; data = 4'hC;
    tick();
    num_checks++;
    if (addA !== 16'h43CF || snap_valid !== 1'b1 || dirty !== 8'h00) begin
      num_fail++; $display("FAIL recapture got addA=%h valid=%b dirty=%h exp 43cf/1/00",
                           addA, snap_valid, dirty);
    end
    snap_req = 0; en = 0;
    tick();
    num_checks++;
    if (snap_valid !== 1'b0 || addA !== 16'h43CF) begin
      num_fail++; $display("FAIL consume got valid=%b addA=%h exp 0/43cf", snap_valid, addA);
    end
  endtask

  task automatic test_clear_priority();
    idle_inputs();
    clr = 1; en = 8'hFF; data = 4'h9; rd_addr_a = 3;
    tick();
    num_checks++;
    if (rdata_a !== 4'h0 || dirty !== 8'hFF) begin
      num_fail++; $display("FAIL clr_prio got rdata_a=%h dirty=%h exp 0/ff", rdata_a, dirty);
    end
    clr = 0; en = 0; snap_req = 1;
    tick();
    snap_req = 0;
    num_checks++;
    if ({addA, addB} !== 32'h0) begin
      num_fail++; $display("FAIL clr_snap got=%h_%h exp=0000_0000", addA, addB);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    snap_ready = 1; snap_req = 1;
    for (int k = 0; k < 6; k++) begin
      en = 8'($urandom); data = 4'($urandom);
      tick();
      num_checks++;
      if (snap_valid !== 1'b1 || snap_drop !== 1'b0 || {addA, addB} !== {m_add_a, m_add_b}) begin
        num_fail++;
        $display("FAIL b2b cyc=%0d got v=%b d=%b ops=%h_%h exp v=1 d=0 ops=%h_%h",
                 k, snap_valid, snap_drop, addA, addB, m_add_a, m_add_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_handshake();
    idle_inputs();
    snap_req = 1;
    tick();
    snap_req = 1; snap_ready = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    num_checks++;
    if (snap_valid !== 1'b0 || snap_drop !== 1'b0) begin
      num_fail++; $display("FAIL rst_mid got valid=%b drop=%b exp 0/0", snap_valid, snap_drop);
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    tick();
    num_checks++;
    if (snap_drop !== 1'b0 || snap_valid !== 1'b0) begin
      num_fail++; $display("FAIL rst_mid_after got valid=%b drop=%b exp 0/0", snap_valid, snap_drop);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      data       = 4'($urandom);
      en         = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      clr        = ($urandom_range(0, 15) == 0);
      rd_addr_a  = 3'($urandom);
      rd_addr_b  = 3'($urandom);
      snap_req   = 1'($urandom);
      snap_ready = ($urandom_range(0, 3) != 0);
      tick();
      num_checks++;
      if (rdata_a !== m_ra || rdata_b !== m_rb) begin
        num_fail++;
        $display("FAIL rand_read cyc=%0d got=%h/%h exp=%h/%h", k, rdata_a, rdata_b, m_ra, m_rb);
      end
      num_checks++;
      if ({addA, addB} !== {m_add_a, m_add_b}) begin
        num_fail++;
        $display("FAIL rand_ops cyc=%0d got=%h_%h exp=%h_%h", k, addA, addB, m_add_a, m_add_b);
      end
      num_checks++;
      if ({snap_valid, snap_drop, dirty} !== {m_valid, m_drop, m_dirty}) begin
        num_fail++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b d=%b dirty=%h exp v=%b d=%b dirty=%h",
                 k, snap_valid, snap_drop, dirty, m_valid, m_drop, m_dirty);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    test_reset();
    test_multi_write();
    test_snapshot_pack();
    test_hold_drop();
    test_accept_recapture();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
